// File: rtl/spi_deserializer.sv
// Receive-side SPI frame checker: oversamples the serializer's lines on clk, shifts bits
// LSB-first and publishes the word on the rising edge of att_cs/del_cs. Optional abort: SPI_DESER_TIMEOUT_EN.
module spi_deserializer #(
    parameter int Register_Width = 32,
    parameter int Shift_BitCount = 32,
    parameter int Timeout_Cycles = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_clk,
    input  logic                      data_bit,
    input  logic                      att_cs,
    input  logic                      del_cs,
    output logic [Register_Width-1:0] Data_Out,
    output logic                      Data_Valid,
    output logic                      Att_Hit,
    output logic                      Del_Hit,
    output logic                      Frame_Err,
    output logic                      Busy
);

    localparam int CntW = $clog2(Shift_BitCount + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Shift_BitCount);

    function automatic logic [Register_Width-1:0] frame_mask();
        logic [Register_Width-1:0] m;
        for (int i = 0; i < Register_Width; i++) begin
            m[i] = (i < Shift_BitCount);
        end
        return m;
    endfunction

    localparam logic [Register_Width-1:0] FrameMask = frame_mask();

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_WAIT_CS_LOW
    } state_t;

    state_t                    state_q;
    logic [2:0]                sck_sync_q;
    logic [2:0]                att_sync_q;
    logic [2:0]                del_sync_q;
    logic [1:0]                dat_sync_q;
    logic [Register_Width-1:0] shreg_q;
    logic [CntW-1:0]           bit_cnt_q;
    logic                      overrun_q;

    logic                      sck_rise;
    logic                      cs_rise;
    logic                      dat_s;
    logic                      att_s;
    logic                      del_s;
    logic [Register_Width-1:0] dat_vec;
    logic                      tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q <= '0;
            att_sync_q <= '0;
            del_sync_q <= '0;
            dat_sync_q <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], spi_clk};
            att_sync_q <= {att_sync_q[1:0], att_cs};
            del_sync_q <= {del_sync_q[1:0], del_cs};
            dat_sync_q <= {dat_sync_q[0], data_bit};
        end
    end

    assign dat_s    = dat_sync_q[1];
    assign att_s    = att_sync_q[1];
    assign del_s    = del_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    // Edge of the combined latch line, so simultaneous att/del pulses give one event.
    assign cs_rise  = (att_s | del_s) & ~(att_sync_q[2] | del_sync_q[2]);
    assign dat_vec  = {{(Register_Width-1){1'b0}}, dat_s};
    assign Busy     = (state_q == ST_SHIFT);

`ifdef SPI_DESER_TIMEOUT_EN
    localparam int TmoW = $clog2(Timeout_Cycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(Timeout_Cycles - 1);

    logic [TmoW-1:0] tmo_cnt_q;

    assign tmo_hit = (state_q == ST_SHIFT) && (tmo_cnt_q == TmoLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_SHIFT && !sck_rise && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Att_Hit    <= 1'b0;
            Del_Hit    <= 1'b0;
            Frame_Err  <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Frame_Err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_rise) begin
                        Frame_Err <= 1'b1;
                        state_q   <= ST_WAIT_CS_LOW;
                    end else if (sck_rise) begin
                        shreg_q   <= dat_vec;
                        bit_cnt_q <= CntW'(1);
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A latch edge coinciding with a clock edge wins; that bit is dropped.
                    if (cs_rise) begin
                        state_q <= ST_LATCH;
                    end else if (sck_rise) begin
                        if (bit_cnt_q < FullCnt) begin
                            shreg_q   <= shreg_q | (dat_vec << bit_cnt_q);
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        Frame_Err <= 1'b1;
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        overrun_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    if (bit_cnt_q == FullCnt && !overrun_q) begin
                        Data_Out   <= shreg_q & FrameMask;
                        Data_Valid <= 1'b1;
                        Att_Hit    <= att_s;
                        Del_Hit    <= del_s;
                    end else begin
                        Frame_Err <= 1'b1;
                    end
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    overrun_q <= 1'b0;
                    state_q   <= ST_WAIT_CS_LOW;
                end
                ST_WAIT_CS_LOW: begin
                    if (!att_s && !del_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
